// File: rtl/hall_pkg.sv
// Shared Hall-sensor definitions: the six legal codes, sequence-neighbour helpers
// and the direction-tracking FSM state type.
package hall_pkg;

  localparam logic [2:0] HALL_101 = 3'b101;
  localparam logic [2:0] HALL_100 = 3'b100;
  localparam logic [2:0] HALL_110 = 3'b110;
  localparam logic [2:0] HALL_010 = 3'b010;
  localparam logic [2:0] HALL_011 = 3'b011;
  localparam logic [2:0] HALL_001 = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    TRACK = 2'd2
  } hall_state_e;

  function automatic logic [2:0] fwd_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      HALL_101: nxt = HALL_100;
      HALL_100: nxt = HALL_110;
      HALL_110: nxt = HALL_010;
      HALL_010: nxt = HALL_011;
      HALL_011: nxt = HALL_001;
      HALL_001: nxt = HALL_101;
      default:  nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] rev_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      HALL_101: nxt = HALL_001;
      HALL_001: nxt = HALL_011;
      HALL_011: nxt = HALL_010;
      HALL_010: nxt = HALL_110;
      HALL_110: nxt = HALL_100;
      HALL_100: nxt = HALL_101;
      default:  nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  function automatic logic is_legal(input logic [2:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

endpackage

// File: rtl/hall_input_conditioner_if.sv
// Raw Hall input and conditioned outputs of one hall_input_conditioner instance.
interface hall_input_conditioner_if #(
  parameter int PERIOD_W = 16
);
  logic [2:0]          hall_raw;
  logic [2:0]          hall_out;
  logic                hall_valid;
  logic                step;
  logic                dir_meas;
  logic                seq_err;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                stall;

  modport master (
    output hall_raw,
    input  hall_out, hall_valid, step, dir_meas, seq_err, period, period_valid, stall
  );

  modport slave (
    input  hall_raw,
    output hall_out, hall_valid, step, dir_meas, seq_err, period, period_valid, stall
  );
endinterface

// File: rtl/hall_deglitch.sv
// Synchronizes the three Hall lines and accepts a new code only after it has been
// sampled identically FILTER_CYCLES times in a row.
module hall_deglitch #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall_raw,
  output logic [2:0] code,
  output logic [2:0] sample,
  output logic       accept
);
  localparam int               RUN_W   = $clog2(FILTER_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0][2:0] sync_r;
  logic [2:0]                  prev_r;
  logic [2:0]                  code_r;
  logic [RUN_W-1:0]            run_r;
  logic [RUN_W-1:0]            run_next_s;
  logic                        accept_s;

  assign sample = sync_r[SYNC_STAGES-1];
  assign code   = code_r;
  assign accept = accept_s;

  // Run length of identical samples; accept fires in the cycle the run completes.
  always_comb begin
    if (sample != prev_r) begin
      run_next_s = RUN_W'(1);
    end else if (run_r >= RUN_MAX) begin
      run_next_s = RUN_MAX;
    end else begin
      run_next_s = run_r + RUN_W'(1);
    end
    accept_s = (run_next_s == RUN_MAX) && (sample != code_r);
  end

  // Synchronizer chain, previous-sample register, run counter and accepted code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 3'b000;
      run_r  <= '0;
      code_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], hall_raw};
      prev_r <= sample;
      run_r  <= run_next_s;
      if (accept_s) begin
        code_r <= sample;
      end
    end
  end

endmodule

// File: rtl/hall_input_conditioner.sv
// Hall input conditioner: deglitched code, validity, step/direction detection,
// sequence-error flagging and commutation-period measurement for the speed loop.
module hall_input_conditioner
  import hall_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int PERIOD_W      = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  hall_input_conditioner_if.slave hif
);
  localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

  logic [2:0]          code_s;
  logic [2:0]          sample_s;
  logic                accept_s;
  logic                step_s;
  logic                seq_err_s;
  logic                dir_s;
  logic                valid_s;
  logic                to_idle_s;
  logic                stall_s;
  logic [PERIOD_W-1:0] cnt_next_s;
  logic [PERIOD_W-1:0] period_next_s;

  hall_state_e         state_r;
  logic                hall_valid_r;
  logic                step_r;
  logic                seq_err_r;
  logic                dir_meas_r;
  logic [PERIOD_W-1:0] period_r;
  logic                period_valid_r;
  logic                stall_r;
  logic [PERIOD_W-1:0] cnt_r;

  hall_deglitch #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_deglitch (
    .clk     (clk),
    .rst_n   (rst_n),
    .hall_raw(hif.hall_raw),
    .code    (code_s),
    .sample  (sample_s),
    .accept  (accept_s)
  );

  // Classify each accepted transition old (code_s) -> new (sample_s).
  always_comb begin
    step_s    = 1'b0;
    seq_err_s = 1'b0;
    dir_s     = dir_meas_r;
    valid_s   = hall_valid_r;
    to_idle_s = 1'b0;
    if (accept_s) begin
      if (!is_legal(sample_s)) begin
        valid_s   = 1'b0;
        to_idle_s = 1'b1;
      end else if (!is_legal(code_s)) begin
        valid_s   = 1'b1;
        to_idle_s = 1'b1;
      end else if (sample_s == fwd_next(code_s)) begin
        step_s = 1'b1;
        dir_s  = 1'b1;
      end else if (sample_s == rev_next(code_s)) begin
        step_s = 1'b1;
        dir_s  = 1'b0;
      end else begin
        seq_err_s = 1'b1;
        to_idle_s = 1'b1;
      end
    end else begin
      valid_s = hall_valid_r;
    end
  end

  // Saturating period counter; period is cnt+1 so N-cycle spacing reads as N.
  always_comb begin
    if (step_s) begin
      cnt_next_s = {PERIOD_W{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_next_s = CNT_MAX;
    end else begin
      cnt_next_s = cnt_r + PERIOD_W'(1);
    end
    if (cnt_r == CNT_MAX) begin
      period_next_s = CNT_MAX;
    end else begin
      period_next_s = cnt_r + PERIOD_W'(1);
    end
    stall_s = (cnt_next_s == CNT_MAX);
  end

  // Direction-tracking FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      hall_valid_r   <= 1'b0;
      step_r         <= 1'b0;
      seq_err_r      <= 1'b0;
      dir_meas_r     <= 1'b1;
      period_r       <= {PERIOD_W{1'b0}};
      period_valid_r <= 1'b0;
      stall_r        <= 1'b0;
      cnt_r          <= {PERIOD_W{1'b0}};
    end else begin
      hall_valid_r <= valid_s;
      step_r       <= step_s;
      seq_err_r    <= seq_err_s;
      dir_meas_r   <= dir_s;
      stall_r      <= stall_s;
      cnt_r        <= cnt_next_s;
      if (to_idle_s || stall_s) begin
        state_r        <= IDLE;
        period_valid_r <= 1'b0;
      end else if (step_s) begin
        // dir_meas_r still holds the direction of the previous step here
        case (state_r)
          IDLE: begin
            state_r        <= LOCK;
            period_valid_r <= 1'b0;
          end
          LOCK: begin
            if (dir_s == dir_meas_r) begin
              state_r        <= TRACK;
              period_r       <= period_next_s;
              period_valid_r <= 1'b1;
            end
          end
          TRACK: begin
            if (dir_s == dir_meas_r) begin
              period_r <= period_next_s;
            end else begin
              state_r        <= LOCK;
              period_valid_r <= 1'b0;
            end
          end
          default: begin
            state_r        <= IDLE;
            period_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hif.hall_out     = code_s;
  assign hif.hall_valid   = hall_valid_r;
  assign hif.step         = step_r;
  assign hif.dir_meas     = dir_meas_r;
  assign hif.seq_err      = seq_err_r;
  assign hif.period       = period_r;
  assign hif.period_valid = period_valid_r;
  assign hif.stall        = stall_r;

endmodule
